tx_credit_scheduler: RTL and testbench

Transmit-side TLP source scheduler for the PCIe transaction layer. It arbitrates between the four TLP sources that feed the TX arbiter: AXI slave write, AXI slave read, AXI master completion and RX router message/completion. It grants one source at a time only when that source's flow-control class has enough header and data credits and the TLP buffer is ready. It holds the grant until fragmentation reports the TLP written. Credit limits come from DLL flow-control updates; consumed credits are tracked locally.

---
 rtl/tx_credit_scheduler_if.sv | 30 +++
 rtl/tx_credit_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_tx_credit_scheduler.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_credit_scheduler_if.sv
// Request/grant and DLL credit-limit bundle between the four TX TLP sources and
// tx_credit_scheduler. The scheduler takes the slave side; the sources take the master side.
interface tx_credit_scheduler_if #(
  parameter int FC_HDR_WIDTH  = 8,
  parameter int FC_DATA_WIDTH = 12
);
  logic [3:0]                 req_valid;
  logic                       rx_is_cpl;
  logic [4*FC_DATA_WIDTH-1:0] req_data_crd;
  logic                       buffer_ready;
  logic                       tlp_done;
  logic                       fc_update_valid;
  logic [1:0]                 fc_type;
  logic [FC_HDR_WIDTH-1:0]    fc_hdr_limit;
  logic [FC_DATA_WIDTH-1:0]   fc_data_limit;
  logic [3:0]                 grant;
  logic                       busy;

  modport master (
    output req_valid, rx_is_cpl, req_data_crd, buffer_ready, tlp_done,
           fc_update_valid, fc_type, fc_hdr_limit, fc_data_limit,
    input  grant, busy
  );

  modport slave (
    input  req_valid, rx_is_cpl, req_data_crd, buffer_ready, tlp_done,
           fc_update_valid, fc_type, fc_hdr_limit, fc_data_limit,
    output grant, busy
  );
endinterface

// File: rtl/tx_credit_scheduler.sv
// Credit-gated round-robin scheduler for the four PCIe TX TLP sources.
// Optional starvation promotion is enabled by defining TX_SCHED_STARVE_EN.
module tx_credit_scheduler #(
  parameter int FC_HDR_WIDTH  = 8,
  parameter int FC_DATA_WIDTH = 12,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  tx_credit_scheduler_if.slave bus
);
  localparam logic [1:0] CLS_P   = 2'd0;
  localparam logic [1:0] CLS_NP  = 2'd1;
  localparam logic [1:0] CLS_CPL = 2'd2;

  localparam logic [FC_HDR_WIDTH-1:0]  HDR_HALF  = {1'b1, {(FC_HDR_WIDTH-1){1'b0}}};
  localparam logic [FC_DATA_WIDTH-1:0] DATA_HALF = {1'b1, {(FC_DATA_WIDTH-1){1'b0}}};
  localparam logic [FC_HDR_WIDTH-1:0]  HDR_ONE   = {{(FC_HDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [2:0][FC_HDR_WIDTH-1:0]  hdr_limit_q, hdr_limit_d;
  logic [2:0][FC_HDR_WIDTH-1:0]  hdr_cons_q, hdr_cons_d;
  logic [2:0][FC_DATA_WIDTH-1:0] data_limit_q, data_limit_d;
  logic [2:0][FC_DATA_WIDTH-1:0] data_cons_q, data_cons_d;

  logic [1:0]               ptr_q, ptr_d;
  logic [1:0]               win_idx_q, win_idx_d;
  logic [1:0]               win_cls_q, win_cls_d;
  logic [FC_DATA_WIDTH-1:0] win_need_q, win_need_d;
  logic [3:0]               grant_q, grant_d;
  logic                     busy_q, busy_d;

  logic [3:0]                    elig;
  logic [3:0][1:0]               src_cls;
  logic [3:0][FC_DATA_WIDTH-1:0] src_need;
  logic                          rr_found;
  logic [1:0]                    rr_idx;
  logic [1:0]                    sel_idx;
  logic                          launch;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
      logic [FC_HDR_WIDTH-1:0]  hdr_lim, hdr_used, hdr_room;
      logic [FC_DATA_WIDTH-1:0] data_lim, data_used, data_room;

      // Sources 0..2 have fixed classes equal to their index; source 3 follows rx_is_cpl.
      if (gi == 3) begin : g_rx
        assign src_cls[gi] = bus.rx_is_cpl ? CLS_CPL : CLS_P;
      end else begin : g_fixed
        assign src_cls[gi] = 2'(gi);
      end

      assign src_need[gi] = bus.req_data_crd[gi*FC_DATA_WIDTH +: FC_DATA_WIDTH];

      always_comb begin
        hdr_lim   = hdr_limit_q[CLS_P];
        hdr_used  = hdr_cons_q[CLS_P];
        data_lim  = data_limit_q[CLS_P];
        data_used = data_cons_q[CLS_P];
        case (src_cls[gi])
          CLS_NP: begin
            hdr_lim   = hdr_limit_q[CLS_NP];
            hdr_used  = hdr_cons_q[CLS_NP];
            data_lim  = data_limit_q[CLS_NP];
            data_used = data_cons_q[CLS_NP];
          end
          CLS_CPL: begin
            hdr_lim   = hdr_limit_q[CLS_CPL];
            hdr_used  = hdr_cons_q[CLS_CPL];
            data_lim  = data_limit_q[CLS_CPL];
            data_used = data_cons_q[CLS_CPL];
          end
          default: ;
        endcase
      end

      // Modular headroom: a result in the upper half means the need overruns the limit.
      assign hdr_room  = hdr_lim - (hdr_used + HDR_ONE);
      assign data_room = data_lim - (data_used + src_need[gi]);
      assign elig[gi]  = bus.req_valid[gi] && (hdr_room <= HDR_HALF) && (data_room <= DATA_HALF);
    end
  endgenerate

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!rr_found && elig[ptr_q + 2'(k)]) begin
        rr_found = 1'b1;
        rr_idx   = ptr_q + 2'(k);
      end
    end
  end

  assign launch = (state_q == ST_IDLE) && rr_found && bus.buffer_ready;

`ifdef TX_SCHED_STARVE_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  logic [3:0] starved;
  logic       st_found;
  logic [1:0] st_idx;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_starve
      logic [STARVE_W-1:0] cnt_q, cnt_d;

      // Only losses while actually eligible count; credit-blocked waiting does not.
      always_comb begin
        cnt_d = cnt_q;
        if (launch) begin
          if (sel_idx == 2'(gi)) begin
            cnt_d = '0;
          end else if (elig[gi] && (cnt_q != STARVE_MAX)) begin
            cnt_d = cnt_q + STARVE_ONE;
          end
        end
      end

      always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign starved[gi] = elig[gi] && (cnt_q == STARVE_MAX);
    end
  endgenerate

  always_comb begin
    st_found = 1'b0;
    st_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (starved[k]) begin
        st_found = 1'b1;
        st_idx   = 2'(k);
      end
    end
  end

  assign sel_idx = st_found ? st_idx : rr_idx;
`else
  assign sel_idx = rr_idx;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = 4'b0000;
    ptr_d      = ptr_q;
    win_idx_d  = win_idx_q;
    win_cls_d  = win_cls_q;
    win_need_d = win_need_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d    = ST_GRANT;
          grant_d    = 4'b0001 << sel_idx;
          win_idx_d  = sel_idx;
          win_cls_d  = src_cls[sel_idx];
          win_need_d = src_need[sel_idx];
        end
      end
      ST_GRANT: begin
        state_d = ST_BUSY;
        ptr_d   = win_idx_q + 2'd1;
      end
      ST_BUSY: begin
        if (bus.tlp_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_BUSY);
  end

  // Limit writes and consumption are independent, so both may hit one class in a cycle.
  always_comb begin
    hdr_limit_d  = hdr_limit_q;
    data_limit_d = data_limit_q;
    hdr_cons_d   = hdr_cons_q;
    data_cons_d  = data_cons_q;
    for (int c = 0; c < 3; c++) begin
      if (bus.fc_update_valid && (bus.fc_type == 2'(c))) begin
        hdr_limit_d[c]  = bus.fc_hdr_limit;
        data_limit_d[c] = bus.fc_data_limit;
      end
      if ((state_q == ST_GRANT) && (win_cls_q == 2'(c))) begin
        hdr_cons_d[c]  = hdr_cons_q[c] + HDR_ONE;
        data_cons_d[c] = data_cons_q[c] + win_need_q;
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q      <= ST_IDLE;
      hdr_limit_q  <= '0;
      hdr_cons_q   <= '0;
      data_limit_q <= '0;
      data_cons_q  <= '0;
      ptr_q        <= 2'd0;
      win_idx_q    <= 2'd0;
      win_cls_q    <= CLS_P;
      win_need_q   <= '0;
      grant_q      <= 4'b0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_limit_q  <= hdr_limit_d;
      hdr_cons_q   <= hdr_cons_d;
      data_limit_q <= data_limit_d;
      data_cons_q  <= data_cons_d;
      ptr_q        <= ptr_d;
      win_idx_q    <= win_idx_d;
      win_cls_q    <= win_cls_d;
      win_need_q   <= win_need_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_tx_credit_scheduler.sv
// Directed bench for tx_credit_scheduler: credit gating, round-robin order, modular wrap,
// asynchronous reset and (when TX_SCHED_STARVE_EN is defined) starvation promotion.
module tb_tx_credit_scheduler;
  localparam int HW = 8;
  localparam int DW = 12;
  localparam int SL = 2;

`ifdef TX_SCHED_STARVE_EN
  localparam logic [3:0] STARVE_STEP_EXP = 4'b0100;
`else
  localparam logic [3:0] STARVE_STEP_EXP = 4'b0010;
`endif

  logic clk  = 1'b0;
  logic arst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   gq[$];
  int   gt[$];

  always #5 clk = ~clk;

  tx_credit_scheduler_if #(.FC_HDR_WIDTH(HW), .FC_DATA_WIDTH(DW)) bus ();

  tx_credit_scheduler #(
    .FC_HDR_WIDTH (HW),
    .FC_DATA_WIDTH(DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_need(input int src, input int val);
    bus.req_data_crd[src*DW +: DW] = DW'(val);
  endtask

  task automatic do_reset();
    arst                = 1'b0;
    bus.req_valid       = 4'b0000;
    bus.rx_is_cpl       = 1'b0;
    bus.req_data_crd    = '0;
    bus.buffer_ready    = 1'b1;
    bus.tlp_done        = 1'b0;
    bus.fc_update_valid = 1'b0;
    bus.fc_type         = 2'd0;
    bus.fc_hdr_limit    = '0;
    bus.fc_data_limit   = '0;
    repeat (2) tick();
    arst = 1'b1;
    tick();
  endtask

  task automatic fc_write(input logic [1:0] t, input int h, input int d);
    bus.fc_update_valid = 1'b1;
    bus.fc_type         = t;
    bus.fc_hdr_limit    = HW'(h);
    bus.fc_data_limit   = DW'(d);
    tick();
    bus.fc_update_valid = 1'b0;
    $display("fc update: type=%0d hdr=%0d data=%0d", t, h, d);
  endtask

  // Runs n cycles, logs every grant and returns tlp_done done_dly cycles after it.
  task automatic run(input int n, input int done_dly);
    int dly;
    dly = -1;
    gq.delete();
    gt.delete();
    for (int i = 0; i < n; i++) begin
      tick();
      bus.tlp_done = 1'b0;
      if (bus.grant != 4'b0000) begin
        check_eq("grant onehot", 32'($countones(bus.grant)), 32'd1);
        for (int s = 0; s < 4; s++) begin
          if (bus.grant[s]) gq.push_back(s);
        end
        gt.push_back(cyc);
        $display("grant: cycle=%0d grant=%b", cyc, bus.grant);
        dly = done_dly;
      end else if (dly > 0) begin
        dly--;
      end
      if (dly == 0) begin
        bus.tlp_done = 1'b1;
        dly = -1;
      end
    end
    bus.tlp_done = 1'b0;
  endtask

  // One request window of up to 8 cycles; a granted TLP is completed before returning.
  task automatic arb(input string tag, input logic [3:0] mask, input logic [3:0] exp);
    logic [3:0] g;
    g = 4'b0000;
    bus.req_valid = mask;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.grant != 4'b0000) begin
        g = bus.grant;
        break;
      end
    end
    bus.req_valid = 4'b0000;
    if (g != 4'b0000) begin
      tick();
      bus.tlp_done = 1'b1;
      tick();
      bus.tlp_done = 1'b0;
    end
    $display("arb %s: req=%b grant=%b", tag, mask, g);
    check_eq(tag, 32'(g), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] acc;

    // Reset values and no grant without credits
    do_reset();
    check_eq("reset grant", 32'(bus.grant), 32'd0);
    check_eq("reset busy", 32'(bus.busy), 32'd0);
    set_need(0, 2);
    bus.req_valid = 4'b0001;
    acc = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      acc = acc | bus.grant;
    end
    check_eq("no credit no grant", 32'(acc), 32'd0);
    fc_write(2'd0, 4, 8);
    check_eq("limit not yet visible", 32'(bus.grant), 32'd0);
    tick();
    check_eq("first grant", 32'(bus.grant), 32'h1);
    tick();
    check_eq("grant is a pulse", 32'(bus.grant), 32'd0);
    check_eq("busy after grant", 32'(bus.busy), 32'd1);
    bus.req_valid = 4'b0000;
    tick();
    check_eq("busy held", 32'(bus.busy), 32'd1);
    bus.tlp_done = 1'b1;
    tick();
    bus.tlp_done = 1'b0;
    check_eq("busy clears on done", 32'(bus.busy), 32'd0);

    // Header limit of 2 allows exactly two grants until the limit is raised
    do_reset();
    fc_write(2'd0, 2, 100);
    bus.req_valid = 4'b0001;
    run(30, 2);
    check_eq("grants at hdr limit 2", 32'(gq.size()), 32'd2);
    fc_write(2'd0, 3, 100);
    run(30, 2);
    check_eq("grants after hdr limit 3", 32'(gq.size()), 32'd1);
    bus.req_valid = 4'b0000;

    // Round-robin order and 3-cycle spacing
    do_reset();
    fc_write(2'd0, 64, 1024);
    fc_write(2'd1, 64, 1024);
    fc_write(2'd2, 64, 1024);
    bus.rx_is_cpl = 1'b1;
    bus.req_valid = 4'b1111;
    run(16, 1);
    bus.req_valid = 4'b0000;
    check_eq("rr grant count", 32'(gq.size() >= 5), 32'd1);
    if (gq.size() >= 5) begin
      check_eq("rr order 0", 32'(gq[0]), 32'd0);
      check_eq("rr order 1", 32'(gq[1]), 32'd1);
      check_eq("rr order 2", 32'(gq[2]), 32'd2);
      check_eq("rr order 3", 32'(gq[3]), 32'd3);
      check_eq("rr order 4", 32'(gq[4]), 32'd0);
      for (int k = 0; k < 4; k++) begin
        check_eq("rr spacing", 32'(gt[k+1] - gt[k]), 32'd3);
      end
    end
    run(4, 1);

    // Class mapping of source 3 and buffer_ready gating
    do_reset();
    fc_write(2'd2, 64, 1024);
    bus.rx_is_cpl = 1'b0;
    arb("src3 as posted blocked", 4'b1000, 4'b0000);
    arb("np without credit", 4'b0010, 4'b0000);
    bus.rx_is_cpl = 1'b1;
    arb("src3 as completion", 4'b1000, 4'b1000);
    bus.buffer_ready = 1'b0;
    arb("buffer not ready", 4'b0100, 4'b0000);
    bus.buffer_ready = 1'b1;
    arb("buffer ready", 4'b0100, 4'b0100);

    // Header headroom boundary: room of exactly half passes, half+1 does not
    do_reset();
    fc_write(2'd0, 130, 0);
    arb("hdr room 129 blocked", 4'b0001, 4'b0000);
    fc_write(2'd0, 129, 0);
    arb("hdr room 128 passes", 4'b0001, 4'b0001);

    // Data counter modular wrap
    do_reset();
    fc_write(2'd0, 64, 4090);
    set_need(0, 2045);
    arb("wrap step 2045 a", 4'b0001, 4'b0001);
    arb("wrap step 2045 b", 4'b0001, 4'b0001);
    set_need(0, 4);
    arb("need 4 over 4090", 4'b0001, 4'b0000);
    fc_write(2'd0, 64, 4094);
    arb("consume to 4094", 4'b0001, 4'b0001);
    arb("need 4 at 4094 blocked", 4'b0001, 4'b0000);
    fc_write(2'd0, 64, 2);
    arb("need 4 after wrap", 4'b0001, 4'b0001);
    set_need(0, 9);
    arb("need 9 blocked", 4'b0001, 4'b0000);

    // Asynchronous reset while busy
    do_reset();
    fc_write(2'd0, 4, 8);
    set_need(0, 2);
    bus.req_valid = 4'b0001;
    tick();
    check_eq("pre-reset grant", 32'(bus.grant), 32'h1);
    bus.req_valid = 4'b0000;
    tick();
    check_eq("pre-reset busy", 32'(bus.busy), 32'd1);
    #2;
    arst = 1'b0;
    #1;
    check_eq("async reset busy", 32'(bus.busy), 32'd0);
    check_eq("async reset grant", 32'(bus.grant), 32'd0);
    tick();
    arst = 1'b1;
    bus.req_valid = 4'b0001;
    run(20, 1);
    check_eq("no grant after reset", 32'(gq.size()), 32'd0);
    bus.req_valid = 4'b0000;
    fc_write(2'd0, 4, 8);
    arb("grant after new update", 4'b0001, 4'b0001);

    // Starvation sequence; only the last step differs between builds
    do_reset();
    bus.rx_is_cpl = 1'b1;
    fc_write(2'd0, 64, 1024);
    fc_write(2'd1, 64, 1024);
    arb("starve step 1", 4'b0111, 4'b0001);
    arb("starve step 2", 4'b0111, 4'b0010);
    arb("starve step 3", 4'b0111, 4'b0001);
    fc_write(2'd2, 64, 1024);
    arb("blocked wait not counted", 4'b0111, 4'b0010);
    arb("src2 by rr turn", 4'b0111, 4'b0100);
    arb("src2 loses to 3", 4'b1100, 4'b1000);
    arb("src2 loses to 0", 4'b0101, 4'b0001);
    arb("src2 promotion", 4'b0110, STARVE_STEP_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
